// File: rtl/jzjpcc_memory_stage.sv
// Memory stage: drives the synchronous data RAM, traps misaligned accesses,
// formats load data and holds the memory-to-writeback register.
// The writeback register output doubles as the bypass path to execute.
module jzjpcc_memory_stage #(
  parameter bit TRAP_ON_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [29:0] memAddress,
  input  logic [1:0]  addrLow,
  input  logic [31:0] memDataToWrite,
  input  logic [3:0]  memByteMask,
  input  logic        memWriteEnable,
  input  logic        memReadEnable,
  input  logic [2:0]  loadFunct3,
  input  logic [31:0] aluResult,
  input  logic [4:0]  rdAddr,
  input  logic        rdWriteEnable,
  input  logic        stall,
  input  logic        flush,
  output logic [29:0] ramAddress,
  output logic [31:0] ramWriteData,
  output logic [3:0]  ramByteEnable,
  output logic        ramWriteEnable,
  input  logic [31:0] ramReadData,
  output logic [31:0] rdWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        rdWriteEnable_wb,
  output logic        fwdEnable,
  output logic        fault,
  output logic [31:0] faultAddress
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] alu;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  low;
  } wb_t;

  wb_t         r_wb;
  logic        r_fault;
  logic [31:0] r_fault_addr;
  logic [31:0] r_hold;
  logic        r_hold_full;

  logic        w_access, w_word, w_half, w_misaligned, w_trap, w_kill;
  logic [31:0] w_src, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_hword;

  // Access size: loads decode funct3, stores infer it from the byte mask
  always_comb begin
    w_access = valid & (memReadEnable | memWriteEnable);
    if (memReadEnable) begin
      w_half = (loadFunct3[1:0] == 2'b01);
      w_word = loadFunct3[1];
    end else begin
      w_half = (memByteMask == 4'b0011) || (memByteMask == 4'b1100);
      w_word = (memByteMask == 4'b1111);
    end
    w_misaligned = w_access & ((w_word & (addrLow != 2'd0)) |
                               (w_half & (addrLow == 2'd3)));
    w_trap = w_misaligned & TRAP_ON_MISALIGNED;
    w_kill = flush | r_fault | w_trap;
  end

  // RAM port is a straight pass-through; the write strobe is gated off by
  // kill, stall and an asserted reset
  assign ramAddress     = memAddress;
  assign ramWriteData   = memDataToWrite;
  assign ramByteEnable  = memByteMask;
  assign ramWriteEnable = reset_n & valid & memWriteEnable & ~w_kill & ~stall;

  // Writeback register advances only when not stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb <= '0;
    end else if (!stall) begin
      r_wb.vld     <= valid & ~w_kill;
      r_wb.rd      <= rdAddr;
      r_wb.rd_we   <= rdWriteEnable;
      r_wb.alu     <= aluResult;
      r_wb.is_load <= memReadEnable;
      r_wb.f3      <= loadFunct3;
      r_wb.low     <= addrLow;
    end
  end

  // RAM data is only valid the cycle after the address; keep it across a stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (!stall) begin
      r_hold_full <= 1'b0;
    end else if (r_wb.vld && r_wb.is_load && !r_hold_full) begin
      r_hold      <= ramReadData;
      r_hold_full <= 1'b1;
    end
  end

  // First trapping access latches its byte address; sticky until reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_trap && !r_fault) begin
      r_fault      <= 1'b1;
      r_fault_addr <= {memAddress, addrLow};
    end
  end

  // Lane select and sign/zero extension of load data
  always_comb begin
    w_src   = r_hold_full ? r_hold : ramReadData;
    w_byte  = w_src[8*r_wb.low +: 8];
    w_hword = w_src[16*r_wb.low[1] +: 16];
    case (r_wb.f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_hword[15]}}, w_hword};
      3'b101:  w_load = {16'd0, w_hword};
      default: w_load = w_src;
    endcase
  end

  assign rdWriteData_wb   = r_wb.is_load ? w_load : r_wb.alu;
  assign rdAddr_wb        = r_wb.rd;
  assign rdWriteEnable_wb = r_wb.vld & r_wb.rd_we;
  assign fwdEnable        = rdWriteEnable_wb & (r_wb.rd != 5'd0);
  assign fault            = r_fault;
  assign faultAddress     = r_fault_addr;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
module tb_jzjpcc_memory_stage;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, valid, memWriteEnable, memReadEnable, rdWriteEnable, stall, flush;
  logic [29:0] memAddress, ramAddress;
  logic [1:0]  addrLow;
  logic [31:0] memDataToWrite, aluResult, ramWriteData, ramReadData, rdWriteData_wb, faultAddress;
  logic [3:0]  memByteMask, ramByteEnable;
  logic [2:0]  loadFunct3;
  logic [4:0]  rdAddr, rdAddr_wb;
  logic        ramWriteEnable, rdWriteEnable_wb, fwdEnable, fault;

  jzjpcc_memory_stage #(.TRAP_ON_MISALIGNED(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .memAddress(memAddress),
    .addrLow(addrLow), .memDataToWrite(memDataToWrite), .memByteMask(memByteMask),
    .memWriteEnable(memWriteEnable), .memReadEnable(memReadEnable),
    .loadFunct3(loadFunct3), .aluResult(aluResult), .rdAddr(rdAddr),
    .rdWriteEnable(rdWriteEnable), .stall(stall), .flush(flush),
    .ramAddress(ramAddress), .ramWriteData(ramWriteData), .ramByteEnable(ramByteEnable),
    .ramWriteEnable(ramWriteEnable), .ramReadData(ramReadData),
    .rdWriteData_wb(rdWriteData_wb), .rdAddr_wb(rdAddr_wb),
    .rdWriteEnable_wb(rdWriteEnable_wb), .fwdEnable(fwdEnable),
    .fault(fault), .faultAddress(faultAddress));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous RAM: 1-cycle read latency, read returns pre-write contents
  logic [31:0] ram [0:255];
  always @(posedge clock) begin
    logic [31:0] w;
    w = ram[ramAddress[7:0]];
    if (ramWriteEnable) begin
      for (int b = 0; b < 4; b++)
        if (ramByteEnable[b]) w[8*b +: 8] = ramWriteData[8*b +: 8];
      ram[ramAddress[7:0]] <= w;
    end
    ramReadData <= ram[ramAddress[7:0]];
  end

  // Reference model: byte-addressed memory plus architectural writeback state
  logic [7:0] refm [0:1023];
  logic        m_vq = 0, m_we = 0, m_fault = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_data = 0, m_fa = 0;

  typedef struct {
    logic        vq, we, fwd, flt;
    logic [4:0]  rd;
    logic [31:0] data, fa;
  } exp_t;
  exp_t q[$];
  exp_t e;

  function automatic logic [31:0] ld_fmt(input logic [29:0] a, input logic [1:0] lo, input logic [2:0] f3);
    int unsigned word, base;
    int v;
    base = {22'd0, a[7:0], 2'b00};
    word = {refm[base+3], refm[base+2], refm[base+1], refm[base]};
    case (f3[1:0])
      2'b00: begin
        v = int'((word >> (8*lo)) & 32'hFF);
        if (!f3[2] && v > 127) v -= 256;
      end
      2'b01: begin
        v = int'((word >> (16*(lo/2))) & 32'hFFFF);
        if (!f3[2] && v > 32767) v -= 65536;
      end
      default: v = int'(word);
    endcase
    return 32'(v);
  endfunction

  task automatic issue(input logic v, input logic [29:0] a, input logic [1:0] lo,
                       input logic [31:0] wd, input logic [3:0] mk, input logic we, re,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rwe, st, fl);
    int sz;
    logic mis, kill, exp_rwe;
    logic [31:0] ld;
    exp_t x;
    @(negedge clock);
    valid = v; memAddress = a; addrLow = lo; memDataToWrite = wd; memByteMask = mk;
    memWriteEnable = we; memReadEnable = re; loadFunct3 = f3; aluResult = alu;
    rdAddr = rd; rdWriteEnable = rwe; stall = st; flush = fl;
    if (re) sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    else    sz = (mk == 4'hF) ? 4 : (mk == 4'h3 || mk == 4'hC) ? 2 : 1;
    mis = v && (re || we) && ((sz == 4 && lo != 0) || (sz == 2 && lo == 3));
    kill = fl || m_fault || mis;
    exp_rwe = v && we && !kill && !st;
    #1;
    chk("ram_we", {31'd0, ramWriteEnable}, {31'd0, exp_rwe});
    if (exp_rwe) chk("ram_addr", {2'b00, ramAddress}, {2'b00, a});
    ld = ld_fmt(a, lo, f3);
    if (exp_rwe)
      for (int b = 0; b < 4; b++)
        if (mk[b]) refm[{a[7:0], 2'(b)}] = wd[8*b +: 8];
    if (!st) begin
      m_vq = v && !kill;
      m_we = m_vq && rwe;
      m_rd = rd;
      m_data = re ? ld : alu;
    end
    if (mis && !m_fault) begin
      m_fault = 1'b1;
      m_fa = {a, lo};
    end
    x.vq = m_vq; x.we = m_we; x.fwd = m_we && (m_rd != 0); x.flt = m_fault;
    x.rd = m_rd; x.data = m_data; x.fa = m_fa;
    q.push_back(x);
  endtask

  // Monitor: compare writeback/bypass/fault outputs after every edge
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wb_we", {31'd0, rdWriteEnable_wb}, {31'd0, e.we});
      chk("wb_rd", {27'd0, rdAddr_wb}, {27'd0, e.rd});
      chk("fwd", {31'd0, fwdEnable}, {31'd0, e.fwd});
      chk("fault", {31'd0, fault}, {31'd0, e.flt});
      chk("fault_addr", faultAddress, e.fa);
      if (e.vq) chk("wb_data", rdWriteData_wb, e.data);
    end
  end

  task automatic rand_instr(input logic allow_stall);
    logic [2:0] f3;
    logic [1:0] lo;
    logic [3:0] mk;
    int typ, kind;
    typ = $urandom_range(0, 2);
    f3 = 3'($urandom_range(0, 7));
    lo = 2'd0; mk = 4'd0;
    if (typ == 1) begin
      if (f3[1:0] == 2'b00) lo = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) lo = 2'($urandom_range(0, 2));
    end else if (typ == 2) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) mk = 4'hF;
      else if (kind == 1) begin lo = 2'($urandom_range(0, 1) * 2); mk = (lo == 0) ? 4'h3 : 4'hC; end
      else begin lo = 2'($urandom_range(0, 3)); mk = 4'(1 << lo); end
    end
    issue($urandom_range(0, 9) != 0, 30'($urandom_range(0, 255)), lo, $urandom, mk,
          typ == 2, typ == 1, f3, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          allow_stall && ($urandom_range(0, 4) == 0), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    for (int i = 0; i < 1024; i++) refm[i] = 8'd0;
    reset_n = 0; valid = 0; memAddress = 0; addrLow = 0; memDataToWrite = 0;
    memByteMask = 0; memWriteEnable = 0; memReadEnable = 0; loadFunct3 = 0;
    aluResult = 0; rdAddr = 0; rdWriteEnable = 0; stall = 0; flush = 0;
    repeat (3) @(negedge clock);
    chk("rst_wb_data", rdWriteData_wb, 32'd0);
    chk("rst_wb_we", {31'd0, rdWriteEnable_wb}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    reset_n = 1;
    // Reset asserted mid-store must drop the write strobe at once
    @(negedge clock);
    valid = 1; memWriteEnable = 1; memByteMask = 4'hF; memAddress = 30'h11;
    memDataToWrite = 32'hCAFEF00D; aluResult = 32'h1234; rdAddr = 5'd3; rdWriteEnable = 1;
    #1 chk("pre_rst_ram_we", {31'd0, ramWriteEnable}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_ram_we", {31'd0, ramWriteEnable}, 32'd0);
    chk("rst_wb_rd", {27'd0, rdAddr_wb}, 32'd0);
    chk("rst_fwd", {31'd0, fwdEnable}, 32'd0);
    chk("rst_fault2", {31'd0, fault}, 32'd0);
    chk("rst_fault_addr", faultAddress, 32'd0);
    @(negedge clock);
    valid = 0; memWriteEnable = 0; rdWriteEnable = 0;
    reset_n = 1;

    // Store then load at byte 0x40
    issue(1, 30'h10, 0, 32'hDEADBEEF, 4'hF, 1, 0, 3'b010, 0, 5'd1, 0, 0, 0);
    issue(1, 30'h10, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd2, 1, 0, 0);
    // Load formatting on 0x80112233
    issue(1, 30'h20, 0, 32'h80112233, 4'hF, 1, 0, 3'b010, 0, 5'd0, 0, 0, 0);
    issue(1, 30'h20, 3, 0, 4'h0, 0, 1, 3'b000, 0, 5'd4, 1, 0, 0);
    issue(1, 30'h20, 3, 0, 4'h0, 0, 1, 3'b100, 0, 5'd4, 1, 0, 0);
    issue(1, 30'h20, 2, 0, 4'h0, 0, 1, 3'b001, 0, 5'd4, 1, 0, 0);
    issue(1, 30'h20, 0, 0, 4'h0, 0, 1, 3'b101, 0, 5'd4, 1, 0, 0);
    // Stall after a load while RAM data changes underneath
    issue(1, 30'h31, 0, 32'hAAAAAAAA, 4'hF, 1, 0, 3'b010, 0, 5'd0, 0, 0, 0);
    issue(1, 30'h30, 0, 32'h12345678, 4'hF, 1, 0, 3'b010, 0, 5'd0, 0, 0, 0);
    issue(1, 30'h30, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd5, 1, 0, 0);
    issue(1, 30'h31, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd6, 1, 1, 0);
    issue(1, 30'h31, 0, 32'h55555555, 4'hF, 1, 0, 3'b010, 0, 5'd6, 1, 1, 0);
    issue(1, 30'h31, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd6, 1, 1, 0);
    issue(1, 30'h31, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd6, 1, 0, 0);
    // Flush and bypass
    issue(1, 30'h05, 0, 32'h11111111, 4'hF, 1, 0, 3'b010, 0, 5'd0, 0, 0, 1);
    issue(1, 30'h05, 0, 0, 4'h0, 0, 1, 3'b010, 0, 5'd8, 1, 0, 0);
    issue(1, 0, 0, 0, 4'h0, 0, 0, 3'b000, 32'h5, 5'd7, 1, 0, 0);
    issue(1, 0, 0, 0, 4'h0, 0, 0, 3'b000, 32'h5, 5'd0, 1, 0, 0);

    for (int i = 0; i < 400; i++) rand_instr(1'b1);

    // Misaligned LW at 0x101 traps; everything after is killed
    issue(1, 30'h40, 1, 0, 4'h0, 0, 1, 3'b010, 0, 5'd3, 1, 0, 0);
    issue(1, 30'h12, 0, 32'h77777777, 4'hF, 1, 0, 3'b010, 0, 5'd3, 1, 0, 0);
    for (int i = 0; i < 30; i++) rand_instr(1'b0);

    @(negedge clock);
    valid = 0; stall = 0; flush = 0;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jzjpcc_memory_stage.md
Name: jzjpcc_memory_stage

Overview:
- Memory stage of the pipelined core. Consumes the execute-to-memory signals and drives a synchronous data RAM with 1-cycle read latency.
- Formats load data (sign/zero extension, byte/half select) and holds the memory-to-writeback pipeline register.
- Exposes a bypass path to execute and traps misaligned accesses.

Parameters:
TRAP_ON_MISALIGNED, 1, 1: misaligned access sets fault and is suppressed; 0: access proceeds on word address, low bits used only for lane select

Ports:
clock  input  1  pipeline clock
reset_n  input  1  asynchronous active-low reset
valid  input  1  instruction present in memory stage
memAddress  input  30  word address [31:2]
addrLow  input  2  byte address [1:0]
memDataToWrite  input  32  store data, already lane-shifted
memByteMask  input  4  store byte enables
memWriteEnable  input  1  instruction is a store
memReadEnable  input  1  instruction is a load
loadFunct3  input  3  load type
aluResult  input  32  non-load result
rdAddr  input  5  destination register
rdWriteEnable  input  1  writes rd
stall  input  1  hold writeback register
flush  input  1  kill incoming instruction
ramAddress  output  30  RAM word address
ramWriteData  output  32  RAM write data
ramByteEnable  output  4  RAM byte enables
ramWriteEnable  output  1  RAM write strobe
ramReadData  input  32  RAM read data, 1 cycle after address
rdWriteData_wb  output  32  value to register file
rdAddr_wb  output  5  destination to register file
rdWriteEnable_wb  output  1  register file write enable (valid_wb & rdWriteEnable_q)
fwdEnable  output  1  bypass valid: rdWriteEnable_wb & rdAddr_wb!=0
fault  output  1  sticky misaligned fault
faultAddress  output  32  byte address of first faulting access

Behaviour:
- Reset (async, reset_n=0): all registers clear, so rdWriteData_wb=0, rdAddr_wb=0, rdWriteEnable_wb=0, fwdEnable=0, fault=0, faultAddress=0, hold register empty. ramWriteEnable is forced 0 during reset.
- Misaligned when (memRead|memWrite) & valid, and either:
  - word access with addrLow!=0;
  - half access (funct3[1:0]=01, or mask 0011/1100 for stores) with addrLow=3.
- kill = flush | fault | (misaligned & TRAP_ON_MISALIGNED).
- RAM outputs are combinational, zero added latency:
  - ramAddress=memAddress, ramWriteData=memDataToWrite, ramByteEnable=memByteMask.
  - ramWriteEnable = valid & memWriteEnable & ~kill & ~stall.
- Writeback register, on a rising edge with ~stall:
  - valid_q <= valid & ~kill.
  - Also captures rdAddr, rdWriteEnable, aluResult, isLoad=memReadEnable, loadFunct3, addrLow.
- Stall: writeback register holds its contents and RAM writes are suppressed. Stall with flush: hold and suppress; flush affects only the incoming instruction.
- Load data is combinational from ramReadData, or from the hold register when it is full:
  - 000 LB: sign-extend the byte at addrLow_q.
  - 100 LBU: zero-extend the byte at addrLow_q.
  - 001 LH: sign-extend the half at addrLow_q[1].
  - 101 LHU: zero-extend the half at addrLow_q[1].
  - 010 and all others: full word.
- rdWriteData_wb = isLoad_q ? loadData : aluResult_q.
- Hold register prevents stale RAM data during stalls:
  - On the first stalled edge with valid_q & isLoad_q & hold empty: capture ramReadData and set full.
  - Cleared on any non-stalled edge.
- Fault: first misaligned access with TRAP_ON_MISALIGNED=1 sets fault and captures faultAddress={memAddress,addrLow}. Both are sticky until reset.
  - Afterwards every access is killed: no RAM writes, valid_q=0.
- Bypass: fwdEnable, rdAddr_wb and rdWriteData_wb are the bypass outputs to execute. rdAddr_wb=0 never forwards.

Test Plan:
1. Reset mid-store: assert reset_n=0 while ramWriteEnable=1 -> ramWriteEnable drops immediately; all _wb outputs 0; fault=0.
2. Store then load: SW to byte address 0x40 with data 0xDEADBEEF and mask 1111 -> ramWriteEnable=1 for 1 cycle at ramAddress=0x10. Then LW to 0x40 with ramReadData=0xDEADBEEF -> next cycle rdWriteData_wb=0xDEADBEEF, rdWriteEnable_wb=1.
3. Load formatting with ramReadData=0x80112233:
   - LB addrLow=3 -> 0xFFFFFF80; LBU addrLow=3 -> 0x00000080.
   - LH addrLow=2 -> 0xFFFF8011; LHU addrLow=0 -> 0x00002233.
4. Stall after a load: load returns 0x12345678, stall held 3 cycles while ramReadData changes to 0xAAAAAAAA -> rdWriteData_wb stays 0x12345678 throughout; no RAM write occurs.
5. Misaligned: LW at byte address 0x101 -> fault=1 and faultAddress=0x00000101 next cycle, rdWriteEnable_wb=0. A following aligned SW produces no ramWriteEnable.
6. Flush and bypass:
   - SW with flush=1 -> ramWriteEnable=0.
   - ADD result 0x5 to rd=7 -> fwdEnable=1, rdAddr_wb=7.
   - Same result to rd=0 -> fwdEnable=0.
